// File: rtl/deser_tp_probe_pkg.sv
// Shared encodings for the deser test-point probe.
// Mode values and reconfiguration blanking length.
package deser_tp_pkg;

  typedef enum logic [1:0] {
    TP_DIRECT  = 2'd0,
    TP_STRETCH = 2'd1,
    TP_TOGGLE  = 2'd2,
    TP_STICKY  = 2'd3
  } tp_mode_e;

  localparam int BLANK_CYCLES = 3;

endpackage

// File: rtl/deser_tp_probe_if.sv
// Probe bus: selects, modes, clears, test points
// and the conditioned outputs with event counts.
interface deser_tp_probe_if
  import deser_tp_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int NBIT = 13,
  parameter int NOUT = 2,
  parameter int CHW  = 2,
  parameter int BITW = 4,
  parameter int CNTW = 16
);

  logic [NOUT*(CHW+BITW)-1:0] sel;
  logic [NOUT*2-1:0]          mode;
  logic [NOUT-1:0]            clr;
  logic [NCH*NBIT-1:0]        tp;
  logic [NOUT-1:0]            tp_out;
  logic [NOUT*CNTW-1:0]       evt_cnt;

  modport master (
    output sel, mode, clr, tp,
    input  tp_out, evt_cnt
  );

  modport slave (
    input  sel, mode, clr, tp,
    output tp_out, evt_cnt
  );

endinterface

// File: rtl/deser_tp_probe_channel.sv
// One probe output: bit/channel select pipeline,
// edge detect, conditioning, blanking, event counter.
module tp_probe_channel
  import deser_tp_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int NBIT    = 13,
  parameter int CHW     = 2,
  parameter int BITW    = 4,
  parameter int STRETCH = 8,
  parameter int CNTW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHW+BITW-1:0] sel,
  input  logic [1:0]          mode,
  input  logic                clr,
  input  logic [NCH*NBIT-1:0] tp,
  output logic                tp_out,
  output logic [CNTW-1:0]     evt_cnt
);

  localparam int SW   = $clog2(STRETCH + 1);
  localparam int CFGW = CHW + BITW + 2;
  localparam logic [SW-1:0] SLOAD = SW'(STRETCH);
  localparam logic [1:0] BLOAD = 2'(BLANK_CYCLES - 1);

  logic [CHW-1:0]  chan;
  logic [BITW-1:0] bsel;
  logic [NCH-1:0]  s1, s1_d;
  logic [(1<<CHW)-1:0] s1x;
  logic            s2, s2_d, s2_prev;
  logic [CFGW-1:0] cfg, cfg_prev;
  logic [1:0]      blank, blank_d;
  logic            chg, blanking, rise;
  logic [SW-1:0]   scnt, scnt_d;
  logic            tog, tog_d;
  logic            stk, stk_d;
  logic            out_d;
  logic [CNTW-1:0] evt_d;

  assign chan = sel[BITW +: CHW];
  assign bsel = sel[BITW-1:0];

  // Zero-padded rows make out-of-range indices read 0.
  for (genvar c = 0; c < NCH; c++) begin : g_s1
    logic [(1<<BITW)-1:0] row;
    always_comb begin
      row = '0;
      row[NBIT-1:0] = tp[c*NBIT +: NBIT];
    end
    assign s1_d[c] = row[bsel];
  end

  always_comb begin
    s1x = '0;
    s1x[NCH-1:0] = s1;
  end

  assign s2_d     = s1x[chan];
  assign cfg      = {sel, mode};
  assign chg      = cfg != cfg_prev;
  assign blanking = chg | (blank != 2'd0);
  assign rise     = s2 & ~s2_prev & ~blanking;

  always_comb begin
    blank_d = blank;
    scnt_d  = '0;
    tog_d   = 1'b0;
    stk_d   = 1'b0;
    evt_d   = '0;
    out_d   = 1'b0;
    if (chg) begin
      blank_d = BLOAD;
    end else if (blank != 2'd0) begin
      blank_d = blank - 1'b1;
    end
    if (!blanking) begin
      if (rise) begin
        scnt_d = SLOAD;
      end else if (scnt != '0) begin
        scnt_d = scnt - 1'b1;
      end
      tog_d = tog ^ rise;
      stk_d = ~clr & (stk | rise);
      evt_d = evt_cnt;
      if (clr) begin
        evt_d = '0;
      end else if (rise && !(&evt_cnt)) begin
        evt_d = evt_cnt + 1'b1;
      end
      unique case (1'b1)
        (mode == TP_DIRECT):  out_d = s2;
        (mode == TP_STRETCH): out_d = scnt_d != '0;
        (mode == TP_TOGGLE):  out_d = tog_d;
        (mode == TP_STICKY):  out_d = stk_d;
      endcase
    end
  end

  // cfg history follows sel/mode through reset too,
  // so configuration held across release is not a change.
  always_ff @(posedge clk) begin
    cfg_prev <= cfg;
    if (!reset) begin
      s1      <= '0;
      s2      <= 1'b0;
      s2_prev <= 1'b0;
      blank   <= 2'd0;
      scnt    <= '0;
      tog     <= 1'b0;
      stk     <= 1'b0;
      tp_out  <= 1'b0;
      evt_cnt <= '0;
    end else begin
      s1      <= s1_d;
      s2      <= s2_d;
      s2_prev <= chg ? 1'b0 : s2;
      blank   <= blank_d;
      scnt    <= scnt_d;
      tog     <= tog_d;
      stk     <= stk_d;
      tp_out  <= out_d;
      evt_cnt <= evt_d;
    end
  end

endmodule

// File: rtl/deser_tp_probe.sv
// Test-point probe mux: NOUT independent conditioned
// probes, each picking one bit of NCH channel buses.
module deser_tp_probe
  import deser_tp_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int NBIT    = 13,
  parameter int NOUT    = 2,
  parameter int CHW     = 2,
  parameter int BITW    = 4,
  parameter int STRETCH = 8,
  parameter int CNTW    = 16
) (
  input logic         clk,
  input logic         reset,
  deser_tp_probe_if.slave bus
);

  localparam int SELW = CHW + BITW;

  logic [NOUT-1:0]      q;
  logic [NOUT*CNTW-1:0] cnt;

  for (genvar o = 0; o < NOUT; o++) begin : g_out
    tp_probe_channel #(
      .NCH(NCH), .NBIT(NBIT), .CHW(CHW),
      .BITW(BITW), .STRETCH(STRETCH), .CNTW(CNTW)
    ) u_chan (
      .clk(clk),
      .reset(reset),
      .sel(bus.sel[o*SELW +: SELW]),
      .mode(bus.mode[o*2 +: 2]),
      .clr(bus.clr[o]),
      .tp(bus.tp),
      .tp_out(q[o]),
      .evt_cnt(cnt[o*CNTW +: CNTW])
    );
  end

  assign bus.tp_out  = q;
  assign bus.evt_cnt = cnt;

endmodule

// File: tb/tb_deser_tp_probe.sv
// Directed and randomized checks of deser_tp_probe
// against a cycle-history reference model.
module tb_deser_tp_probe;

  localparam int NCH = 4, NBIT = 13, NOUT = 2;
  localparam int CHW = 2, BITW = 4, STR = 8, CNTW = 4;
  localparam int MAXC = 15;
  localparam int NRND = 600;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  deser_tp_probe_if #(
    .NCH(NCH), .NBIT(NBIT), .NOUT(NOUT),
    .CHW(CHW), .BITW(BITW), .CNTW(CNTW)
  ) bus ();

  deser_tp_probe #(
    .NCH(NCH), .NBIT(NBIT), .NOUT(NOUT), .CHW(CHW),
    .BITW(BITW), .STRETCH(STR), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // reference model state, histories indexed by cycle
  bit mdl_on = 0;
  int n = 0;
  logic [51:0] tph [0:1023];
  int bith [0:1][0:1023];
  int chh [0:1][0:1023];
  logic [7:0] cfgh [0:1][0:1023];
  bit chgh [0:1][0:1023];
  logic [7:0] cfg_rst [0:1];
  int m_out [0:1];
  int m_evt [0:1];
  int m_tog [0:1];
  int m_stk [0:1];
  int m_lr [0:1];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int evt(input int o);
    return int'(bus.evt_cnt[o*CNTW +: CNTW]);
  endfunction

  function automatic int outp(input int o);
    return int'(bus.tp_out[o]);
  endfunction

  task automatic setsel(input int o, input int ch, input int b);
    bus.sel[o*6 +: 6] = {2'(ch), 4'(b)};
  endtask

  task automatic setmode(input int o, input int m);
    bus.mode[o*2 +: 2] = 2'(m);
  endtask

  // s2 in cycle m: bit chosen two cycles back, channel one back
  function automatic int s2f(input int o, input int m);
    int b, c;
    if (m < 2) return 0;
    b = bith[o][m-2];
    c = chh[o][m-1];
    if (b >= NBIT || c >= NCH) return 0;
    return int'(tph[m-2][c*NBIT + b]);
  endfunction

  task automatic model_step();
    tph[n] = bus.tp;
    for (int o = 0; o < NOUT; o++) begin
      int s2, s2p, rise;
      bit blank;
      bith[o][n] = int'(bus.sel[o*6 +: 4]);
      chh[o][n]  = int'(bus.sel[o*6+4 +: 2]);
      cfgh[o][n] = {bus.sel[o*6 +: 6], bus.mode[o*2 +: 2]};
      chgh[o][n] = cfgh[o][n] != (n == 0 ? cfg_rst[o] : cfgh[o][n-1]);
      blank = chgh[o][n] || (n >= 1 && chgh[o][n-1])
              || (n >= 2 && chgh[o][n-2]);
      s2  = s2f(o, n);
      s2p = (n == 0 || chgh[o][n-1]) ? 0 : s2f(o, n-1);
      rise = (s2 == 1 && s2p == 0 && !blank) ? 1 : 0;
      if (blank) begin
        m_out[o] = 0; m_evt[o] = 0; m_tog[o] = 0;
        m_stk[o] = 0; m_lr[o] = -1000;
      end else begin
        if (rise == 1) begin
          m_lr[o] = n;
          m_tog[o] = 1 - m_tog[o];
        end
        if (bus.clr[o]) begin
          m_stk[o] = 0;
          m_evt[o] = 0;
        end else begin
          if (rise == 1) m_stk[o] = 1;
          if (rise == 1 && m_evt[o] < MAXC) m_evt[o]++;
        end
        case (int'(bus.mode[o*2 +: 2]))
          0: m_out[o] = s2;
          1: m_out[o] = (n - m_lr[o] < STR) ? 1 : 0;
          2: m_out[o] = m_tog[o];
          default: m_out[o] = m_stk[o];
        endcase
      end
    end
    n++;
  endtask

  task automatic tick();
    if (mdl_on) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic pulse_train(input int o, input int p, input int np,
                             input int gap, input int w,
                             output int first, output int last,
                             output int cnt);
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < w; i++) begin
      bus.tp[p] = (i % gap == 0) && (i / gap < np);
      tick();
      if (bus.tp_out[o]) begin
        if (first < 0) first = i + 1;
        last = i + 1;
        cnt++;
      end
    end
    bus.tp[p] = 1'b0;
  endtask

  initial begin
    int f, l, c;
    bus.tp = '1;
    bus.clr = '0;
    bus.mode = '0;
    bus.sel = '0;
    setsel(0, 2, 5);

    // reset holds everything at zero despite tp all ones
    wait_n(2);
    chk("rst_out", int'(bus.tp_out), 0);
    chk("rst_evt", int'(bus.evt_cnt), 0);
    bus.tp = '0;
    tick();
    reset = 1'b1;
    wait_n(3);
    bus.tp[2*13+5] = 1'b1;
    tick();
    chk("dir_lat1", outp(0), 0);
    tick();
    chk("dir_lat2", outp(0), 0);
    tick();
    chk("dir_lat3", outp(0), 1);
    chk("dir_evt", evt(0), 1);

    // bit index beyond NBIT reads 0
    bus.tp = '1;
    for (int b = 13; b < 16; b++) begin
      setsel(0, 2, b);
      wait_n(8);
      chk($sformatf("oor_out_b%0d", b), outp(0), 0);
      chk($sformatf("oor_evt_b%0d", b), evt(0), 0);
    end

    // stretch: single pulse, then retriggered pair
    bus.tp = '0;
    setsel(0, 1, 3);
    setmode(0, 1);
    wait_n(6);
    pulse_train(0, 16, 1, 2, 16, f, l, c);
    chk("str1_first", f, 3);
    chk("str1_len", c, 8);
    chk("str1_last", l, 10);
    bus.clr[0] = 1'b1;
    tick();
    bus.clr[0] = 1'b0;
    chk("str_clr", evt(0), 0);
    pulse_train(0, 16, 2, 5, 24, f, l, c);
    chk("str2_first", f, 3);
    chk("str2_last", l, 15);
    chk("str2_len", c, 13);
    chk("str2_evt", evt(0), 2);

    // toggle
    setmode(0, 2);
    wait_n(6);
    pulse_train(0, 16, 3, 2, 12, f, l, c);
    chk("tog_out", outp(0), 1);
    chk("tog_evt", evt(0), 3);

    // sticky, then clr coincident with a rise
    setmode(0, 3);
    wait_n(6);
    pulse_train(0, 16, 1, 2, 6, f, l, c);
    chk("stk_out", outp(0), 1);
    chk("stk_evt", evt(0), 1);
    bus.tp[16] = 1'b1;
    tick();
    bus.tp[16] = 1'b0;
    tick();
    bus.clr[0] = 1'b1;
    tick();
    bus.clr[0] = 1'b0;
    chk("stk_clr_out", outp(0), 0);
    chk("stk_clr_evt", evt(0), 0);
    wait_n(3);
    chk("stk_hold", outp(0), 0);

    // counter saturation
    setmode(0, 0);
    wait_n(6);
    pulse_train(0, 16, 20, 2, 44, f, l, c);
    chk("sat_evt", evt(0), 15);
    bus.clr[0] = 1'b1;
    tick();
    bus.clr[0] = 1'b0;
    chk("sat_clr", evt(0), 0);
    pulse_train(0, 16, 1, 2, 5, f, l, c);
    chk("sat_next", evt(0), 1);

    // reconfiguration blanking on output 1 only
    bus.tp[16] = 1'b1;
    setsel(1, 3, 0);
    setmode(1, 3);
    wait_n(6);
    pulse_train(1, 39, 1, 2, 6, f, l, c);
    chk("rcf_pre1", outp(1), 1);
    chk("rcf_pre0", outp(0), 1);
    setsel(1, 3, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("rcf_blank%0d", i), outp(1), 0);
      chk($sformatf("rcf_o0_%0d", i), outp(0), 1);
    end
    chk("rcf_evt", evt(1), 0);

    // a second change one cycle later restarts the window
    setmode(1, 0);
    bus.tp[40] = 1'b1;
    bus.tp[41] = 1'b1;
    wait_n(6);
    chk("ext_pre", outp(1), 1);
    setsel(1, 3, 2);
    tick();
    chk("ext_e1", outp(1), 0);
    setsel(1, 3, 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("ext_e%0d", i), outp(1), 0);
      chk($sformatf("ext_o0_%0d", i), outp(0), 1);
    end
    tick();
    chk("ext_e5", outp(1), 1);

    // randomized run against the reference model
    reset = 1'b0;
    bus.clr = '0;
    for (int o = 0; o < NOUT; o++) begin
      setsel(o, $urandom_range(0, 3), $urandom_range(0, 15));
      setmode(o, $urandom_range(0, 3));
    end
    wait_n(2);
    for (int o = 0; o < NOUT; o++) begin
      cfg_rst[o] = {bus.sel[o*6 +: 6], bus.mode[o*2 +: 2]};
      m_out[o] = 0; m_evt[o] = 0; m_tog[o] = 0;
      m_stk[o] = 0; m_lr[o] = -1000;
    end
    n = 0;
    mdl_on = 1;
    reset = 1'b1;
    for (int k = 0; k < NRND; k++) begin
      bus.tp = bus.tp ^ (52'({$urandom(), $urandom()})
                       & 52'({$urandom(), $urandom()}));
      for (int o = 0; o < NOUT; o++) begin
        if ($urandom_range(0, 19) == 0) begin
          setsel(o, $urandom_range(0, 3), $urandom_range(0, 15));
          setmode(o, $urandom_range(0, 3));
        end
        bus.clr[o] = ($urandom_range(0, 9) == 0);
      end
      tick();
      for (int o = 0; o < NOUT; o++) begin
        chk($sformatf("rnd_out%0d_c%0d", o, k), outp(o), m_out[o]);
        chk($sformatf("rnd_evt%0d_c%0d", o, k), evt(o), m_evt[o]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
